// File: rtl/ticket_payment_ctrl_if.sv
// Order/coin/dispense signal bundle between the UI driver and ticket_payment_ctrl.
// master drives order and coin inputs; slave is the payment controller.
interface ticket_payment_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] total;
    logic [WIDTH-1:0] ticket;
    logic             coin_valid;
    logic [WIDTH-1:0] coin_val;
    logic             cancel;
    logic             busy;
    logic [WIDTH-1:0] paid;
    logic             ticket_pulse;
    logic [WIDTH-1:0] change;
    logic             change_valid;
    logic             done;
    logic             coin_reject;

    modport master (
        output start, total, ticket, coin_valid, coin_val, cancel,
        input  busy, paid, ticket_pulse, change, change_valid, done, coin_reject
    );

    modport slave (
        input  start, total, ticket, coin_valid, coin_val, cancel,
        output busy, paid, ticket_pulse, change, change_valid, done, coin_reject
    );
endinterface

// File: rtl/ticket_payment_ctrl.sv
// Payment/dispense controller: latches an order, accumulates coins, issues tickets, returns change.
// Optional macro TIMEOUT_EN: refund automatically after TIMEOUT coin-less cycles in PAY.
module ticket_payment_ctrl #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 30
) (
    input logic                clk,
    input logic                rst_n,
    ticket_payment_ctrl_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_PAY, S_ISSUE, S_SETTLE, S_REFUND} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] total_l, ticket_l, paid_q, change_q, issued_q, paid_next;
    logic [WIDTH:0]   coin_sum;
    logic             coin_ok, order_ok, last_ticket, timeout_hit;

    // Carry bit of the widened sum flags a coin that would overflow the money bus.
    function automatic logic [WIDTH:0] money_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    always_comb begin
        coin_sum    = money_add(paid_q, bus.coin_val);
        coin_ok     = (state_q == S_PAY) && bus.coin_valid && !bus.cancel && !coin_sum[WIDTH];
        paid_next   = coin_ok ? coin_sum[WIDTH-1:0] : paid_q;
        order_ok    = bus.start && (bus.ticket != '0);
        last_ticket = (issued_q == ticket_l - WIDTH'(1));
    end

`ifdef TIMEOUT_EN
    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] idle_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
        end else if (state_q != S_PAY || coin_ok) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + CNT_W'(1);
        end
    end

    assign timeout_hit = (state_q == S_PAY) && !coin_ok && (idle_cnt_q == CNT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Cancel outranks payment completion; a free order leaves PAY on its first cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (order_ok) state_d = S_PAY;
            S_PAY: begin
                if (bus.cancel)                state_d = S_REFUND;
                else if (paid_next >= total_l) state_d = S_ISSUE;
                else if (timeout_hit)          state_d = S_REFUND;
            end
            S_ISSUE:  if (last_ticket) state_d = S_SETTLE;
            S_SETTLE: state_d = S_IDLE;
            S_REFUND: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_l  <= '0;
            ticket_l <= '0;
            paid_q   <= '0;
            change_q <= '0;
            issued_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (order_ok) begin
                        total_l  <= bus.total;
                        ticket_l <= bus.ticket;
                        paid_q   <= '0;
                    end
                end
                S_PAY: begin
                    paid_q   <= paid_next;
                    issued_q <= '0;
                    if (state_d == S_REFUND) change_q <= paid_q;
                end
                S_ISSUE: begin
                    issued_q <= issued_q + WIDTH'(1);
                    if (last_ticket) change_q <= paid_q - total_l;
                end
                default: paid_q <= '0;
            endcase
        end
    end

    always_comb begin
        bus.busy         = (state_q != S_IDLE);
        bus.paid         = paid_q;
        bus.ticket_pulse = (state_q == S_ISSUE);
        bus.change       = change_q;
        bus.change_valid = (state_q == S_SETTLE) || (state_q == S_REFUND);
        bus.done         = (state_q == S_SETTLE);
        bus.coin_reject  = bus.coin_valid && !coin_ok;
    end
endmodule

// File: tb/tb_ticket_payment_ctrl.sv
// Scoreboard bench for ticket_payment_ctrl: stimulus pushes predicted settlements and coin verdicts,
// a negedge monitor pops and compares them as the DUT presents change_valid / coin_valid.
module tb_ticket_payment_ctrl;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ticket_payment_ctrl_if #(.WIDTH(8)) bus ();

    ticket_payment_ctrl #(.WIDTH(8), .TIMEOUT(30)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int change;
        int done;
        int pulses;
    } exp_t;

    exp_t exp_q[$];
    int   rej_q[$];
    int   coin_list[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pulse counting and settlement comparison
    int pcnt = 0;
    bit prev_pulse = 0;
    bit gap = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pcnt = 0;
            prev_pulse = 0;
            gap = 0;
        end else begin
            if (bus.coin_valid) begin
                if (rej_q.size() == 0) begin
                    chk("coin_reject_unexpected_coin", 1, 0);
                end else begin
                    chk("coin_reject", int'(bus.coin_reject), rej_q.pop_front());
                end
            end
            if (bus.ticket_pulse) begin
                if (pcnt > 0 && !prev_pulse) gap = 1;
                pcnt++;
            end
            prev_pulse = bus.ticket_pulse;
            if (bus.done && !bus.change_valid) chk("done_without_change_valid", 1, 0);
            if (bus.change_valid) begin
                if (exp_q.size() == 0) begin
                    chk("change_valid_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("change", int'(bus.change), e.change);
                    chk("done", int'(bus.done), e.done);
                    chk("ticket_pulses", pcnt, e.pulses);
                    chk("pulse_gap", int'(gap), 0);
                end
                pcnt = 0;
                gap = 0;
            end
        end
    end

    // Reference: paid accumulates accepted coins (sum must fit 8 bits); order completes as soon
    // as paid >= total; cancel refunds everything paid so far.
    task automatic place(input int tot, input int tk, input int cancel_at,
                         input bit auto_cancel, output bit reached);
        int p;
        int i;
        bit fin;
        exp_t e;
        p = 0; i = 0; fin = 0; reached = 0;
        bus.start = 1'b1; bus.total = 8'(tot); bus.ticket = 8'(tk);
        @(posedge clk); #1;
        chk("busy_after_start", int'(bus.busy), 1);
        while (!fin) begin
            bus.start  = 1'($urandom_range(0, 1));
            bus.total  = 8'($urandom);
            bus.ticket = 8'($urandom_range(1, 9));
            if (p >= tot) begin
                e.change = p - tot; e.done = 1; e.pulses = tk;
                exp_q.push_back(e);
                fin = 1;
                reached = (i > 0);
            end else if (i == cancel_at || (i >= coin_list.size() && auto_cancel)) begin
                bus.cancel = 1'b1;
                if (i < coin_list.size()) begin
                    bus.coin_valid = 1'b1;
                    bus.coin_val   = 8'(coin_list[i]);
                    rej_q.push_back(1);
                end
                e.change = p; e.done = 0; e.pulses = 0;
                exp_q.push_back(e);
                @(posedge clk); #1;
                chk("paid_at_refund", int'(bus.paid), p);
                fin = 1;
            end else if (i < coin_list.size()) begin
                bus.coin_valid = 1'b1;
                bus.coin_val   = 8'(coin_list[i]);
                if (p + coin_list[i] <= 255) begin
                    p = p + coin_list[i];
                    rej_q.push_back(0);
                end else begin
                    rej_q.push_back(1);
                end
                @(posedge clk); #1;
                chk("paid", int'(bus.paid), p);
                i++;
            end else begin
                e.change = p; e.done = 0; e.pulses = 0;
                exp_q.push_back(e);
                fin = 1;
            end
            bus.coin_valid = 1'b0;
            bus.cancel     = 1'b0;
        end
        bus.start = 1'b0;
        if (reached) chk("pulse_latency", int'(bus.ticket_pulse), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_idle_bound", int'(bus.busy), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_paid"}, int'(bus.paid), 0);
        chk({tag, "_ticket_pulse"}, int'(bus.ticket_pulse), 0);
        chk({tag, "_change"}, int'(bus.change), 0);
        chk({tag, "_change_valid"}, int'(bus.change_valid), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_coin_reject"}, int'(bus.coin_reject), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit r;
        int vals[6];
        int tot, tk, n, ca;
        vals = '{1, 2, 5, 10, 20, 50};
        bus.start = 0; bus.total = 0; bus.ticket = 0;
        bus.coin_valid = 0; bus.coin_val = 0; bus.cancel = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        coin_list = '{10, 5, 5};
        place(20, 5, -1, 1, r); wait_idle();
        coin_list = '{20};
        place(15, 2, -1, 1, r); wait_idle();
        coin_list = '{10, 5, 10};
        place(30, 1, 2, 1, r); wait_idle();
        coin_list = '{200, 50, 10, 5};
        place(255, 1, -1, 1, r); wait_idle();

        bus.coin_valid = 1'b1; bus.coin_val = 8'd7;
        rej_q.push_back(1);
        @(posedge clk); #1;
        bus.coin_valid = 1'b0;
        chk("idle_coin_busy", int'(bus.busy), 0);
        bus.start = 1'b1; bus.total = 8'd5; bus.ticket = 8'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("zero_ticket_busy", int'(bus.busy), 0);

        coin_list = '{10};
        place(10, 4, -1, 1, r);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_all_zero("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        coin_list = '{5, 5};
        place(10, 3, -1, 1, r); wait_idle();

        coin_list = '{5};
        place(50, 1, -1, 0, r);
`ifdef TIMEOUT_EN
        wait_idle();
`else
        repeat (100) @(posedge clk);
        #1;
        chk("no_timeout_busy", int'(bus.busy), 1);
        chk("no_timeout_paid", int'(bus.paid), 5);
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        wait_idle();
`endif

        for (int k = 0; k < 40; k++) begin
            tot = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 60);
            tk  = $urandom_range(1, 6);
            n   = $urandom_range(1, 8);
            coin_list.delete();
            for (int j = 0; j < n; j++) coin_list.push_back(vals[$urandom_range(0, 5)]);
            ca = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n) : -1;
            place(tot, tk, ca, 1, r);
            if (r && $urandom_range(0, 1) == 1) begin
                bus.cancel = 1'b1;
                @(posedge clk); #1;
                bus.cancel = 1'b0;
            end
            wait_idle();
            if ($urandom_range(0, 3) == 0) begin
                bus.coin_valid = 1'b1; bus.coin_val = 8'($urandom_range(1, 50));
                rej_q.push_back(1);
                @(posedge clk); #1;
                bus.coin_valid = 1'b0;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("exp_queue_drained", exp_q.size(), 0);
        chk("reject_queue_drained", rej_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
